// File: rtl/walk_request_conditioner.sv
// ============================================================================
// walk_request_conditioner
//   Synchronizes and debounces the raw WalkButton and turns it into a sticky
//   walk request that is cleared by walk_ack and followed by a re-request lockout.
//   Optional: WALK_PRESS_COUNT_EN enables the saturating press_count counter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module walk_request_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int DB_W            = 20,
  parameter int LOCKOUT_CYCLES  = 100000000,
  parameter int LK_W            = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       WalkButton,
  input  logic       walk_ack,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       walk_req,
  output logic       lockout_active,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LK_W-1:0] LK_LOAD = LK_W'(LOCKOUT_CYCLES);

  logic            sync1_q, sync2_q;
  state_t          state_q, state_d;
  logic [DB_W-1:0] dcnt_q, dcnt_d;
  logic [LK_W-1:0] lk_q, lk_d;
  logic            press_q, press_d;
  logic            level_q, level_d;
  logic            req_q, req_d;
  logic            lk_act_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= WalkButton;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= RELEASED;
      dcnt_q   <= '0;
      press_q  <= 1'b0;
      level_q  <= 1'b0;
      req_q    <= 1'b0;
      lk_q     <= '0;
      lk_act_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      dcnt_q   <= dcnt_d;
      press_q  <= press_d;
      level_q  <= level_d;
      req_q    <= req_d;
      lk_q     <= lk_d;
      lk_act_q <= (lk_d != '0);
    end
  end

  always_comb begin
    state_d = state_q;
    dcnt_d  = dcnt_q;
    press_d = 1'b0;
    case (state_q)
      RELEASED: begin
        if (sync2_q) begin
          state_d = PRESS_WAIT;
          dcnt_d  = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync2_q) begin
          state_d = RELEASED;
        end else if (dcnt_q == DB_LAST) begin
          state_d = HELD;
          press_d = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DB_W'(1);
        end
      end
      HELD: begin
        if (!sync2_q) begin
          state_d = RELEASE_WAIT;
          dcnt_d  = '0;
        end
      end
      RELEASE_WAIT: begin
        // A bounce back to 1 returns to HELD silently: it is the same press.
        if (sync2_q) begin
          state_d = HELD;
        end else if (dcnt_q == DB_LAST) begin
          state_d = RELEASED;
        end else begin
          dcnt_d = dcnt_q + DB_W'(1);
        end
      end
      default: begin
        state_d = RELEASED;
        dcnt_d  = '0;
      end
    endcase
  end

  always_comb begin
    level_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
    // walk_req is registered alongside press_pulse so both rise together.
    if (walk_ack) begin
      req_d = 1'b0;
    end else if (press_d && (lk_q == '0)) begin
      req_d = 1'b1;
    end else begin
      req_d = req_q;
    end
    if (walk_ack) begin
      lk_d = LK_LOAD;
    end else if (lk_q != '0) begin
      lk_d = lk_q - LK_W'(1);
    end else begin
      lk_d = lk_q;
    end
  end

  assign btn_level      = level_q;
  assign press_pulse    = press_q;
  assign walk_req       = req_q;
  assign lockout_active = lk_act_q;

`ifdef WALK_PRESS_COUNT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else if (press_q && (cnt_q != 8'hFF)) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign press_count = cnt_q;
`else
  assign press_count = 8'd0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_walk_request_conditioner.sv
// Self-checking bench for walk_request_conditioner against a run-length debounce model.
`default_nettype none

module tb_walk_request_conditioner;

  localparam int DB = 4;
  localparam int LK = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       WalkButton = 1'b0;
  logic       walk_ack = 1'b0;
  logic       btn_level, press_pulse, walk_req, lockout_active;
  logic [7:0] press_count;

  int checks = 0;
  int failures = 0;

  // Reference state: synchronizer pipe, accepted level, run length of disagreeing samples.
  logic m_ff1, m_ff2, m_level, m_pulse, m_req;
  int   m_run, m_lk, m_cnt;

  walk_request_conditioner #(
    .DEBOUNCE_CYCLES(DB), .DB_W(3), .LOCKOUT_CYCLES(LK), .LK_W(4)
  ) dut (
    .clk(clk), .rst(rst), .WalkButton(WalkButton), .walk_ack(walk_ack),
    .btn_level(btn_level), .press_pulse(press_pulse), .walk_req(walk_req),
    .lockout_active(lockout_active), .press_count(press_count)
  );

  always #5 clk = ~clk;

  function automatic logic [11:0] dut_vec();
    return {btn_level, press_pulse, walk_req, lockout_active, press_count};
  endfunction

  function automatic logic [11:0] exp_vec();
    logic [7:0] c;
`ifdef WALK_PRESS_COUNT_EN
    c = 8'(m_cnt);
`else
    c = 8'd0;
`endif
    return {m_level, m_pulse, m_req, (m_lk != 0), c};
  endfunction

  // Press will be accepted on the next edge if the input stays high.
  function automatic bit press_next();
    return (m_level == 1'b0) && (m_ff2 == 1'b1) && (m_run == DB);
  endfunction

  task automatic model_edge(input logic b, input logic ack, input logic r);
    logic s, press;
    if (r) begin
      m_ff1 = 0; m_ff2 = 0; m_level = 0; m_pulse = 0; m_req = 0;
      m_run = 0; m_lk = 0; m_cnt = 0;
    end else begin
      s = m_ff2;
      m_ff2 = m_ff1;
      m_ff1 = b;
      press = 1'b0;
      if (s != m_level) begin
        m_run++;
        if (m_run == DB + 1) begin
          m_level = s;
          m_run = 0;
          press = s;
        end
      end else begin
        m_run = 0;
      end
      if (m_pulse && m_cnt < 255) m_cnt++;
      if (ack) m_req = 1'b0;
      else if (press && m_lk == 0) m_req = 1'b1;
      if (ack) m_lk = LK;
      else if (m_lk > 0) m_lk--;
      m_pulse = press;
    end
  endtask

  task automatic drive(input logic b, input logic ack, input logic r);
    WalkButton = b;
    walk_ack   = ack;
    rst        = r;
    @(posedge clk);
    model_edge(b, ack, r);
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    checks++;
    if (dut_vec() !== 12'd0) begin
      failures++;
      $display("FAIL reset: got %b expected %b", dut_vec(), 12'd0);
    end
    drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_clean_press();
    int pulses = 0;
    int pulse_cyc = -1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL clean_press cyc%0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
      if (press_pulse === 1'b1) begin
        pulses++;
        if (pulse_cyc < 0) pulse_cyc = i;
      end
    end
    checks++;
    if (pulses !== 1 || pulse_cyc !== 6) begin
      failures++;
      $display("FAIL clean_press_pulse: got %0d pulses at drive %0d expected 1 at drive 6", pulses, pulse_cyc);
    end
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, 1'b0);
    checks++;
    if (dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL clean_release: got %b expected %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    for (int i = 0; i < 20; i++) begin
      drive((i < 8) ? ((i % 2) == 0) : 1'b0, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL bounce cyc%0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
      if (press_pulse === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0 || btn_level !== 1'b0) begin
      failures++;
      $display("FAIL bounce_pulse: got pulses=%0d level=%b expected 0 and 0", pulses, btn_level);
    end
  endtask

  task automatic test_ack_lockout();
    drive(1'b0, 1'b1, 1'b0);
    checks++;
    if (walk_req !== 1'b0 || lockout_active !== 1'b1) begin
      failures++;
      $display("FAIL ack: got req=%b lk=%b expected req=0 lk=1", walk_req, lockout_active);
    end
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL lockout_press cyc%0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
    end
    for (int i = 0; i < 30; i++) begin
      drive((i >= 14), 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL after_lockout cyc%0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
    end
    checks++;
    if (walk_req !== 1'b1 || lockout_active !== 1'b0) begin
      failures++;
      $display("FAIL post_lockout_req: got req=%b lk=%b expected req=1 lk=0", walk_req, lockout_active);
    end
  endtask

  task automatic test_simultaneous();
    int guard = 0;
    drive(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b0);
    while (!press_next() && guard < 20) begin
      drive(1'b1, 1'b0, 1'b0);
      guard++;
    end
    checks++;
    if (guard >= 20) begin
      failures++;
      $display("FAIL simul_setup: got timeout %0d expected < 20", guard);
    end
    drive(1'b1, 1'b1, 1'b0);
    checks++;
    if (press_pulse !== 1'b1 || walk_req !== 1'b0 || lockout_active !== 1'b1) begin
      failures++;
      $display("FAIL simultaneous: got pulse=%b req=%b lk=%b expected 1 0 1", press_pulse, walk_req, lockout_active);
    end
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int pulse_at = -1;
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1);
    checks++;
    if (dut_vec() !== 12'd0) begin
      failures++;
      $display("FAIL reset_mid: got %b expected %b", dut_vec(), 12'd0);
    end
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, 1'b0);
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL reset_mid_hold cyc%0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
      if (press_pulse === 1'b1 && pulse_at < 0) pulse_at = i;
    end
    checks++;
    if (pulse_at !== 6) begin
      failures++;
      $display("FAIL reset_mid_latency: got pulse at %0d expected 6", pulse_at);
    end
    for (int i = 0; i < 12; i++) drive(1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    logic b = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 2) b = ~b;
      drive(b, ($urandom_range(0, 99) < 2), ($urandom_range(0, 499) == 0));
      checks++;
      if (dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random cyc%0d: got %b expected %b", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_saturation();
    logic [7:0] want;
    drive(1'b0, 1'b0, 1'b1);
    for (int p = 0; p < 260; p++) begin
      for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) drive(1'b0, 1'b0, 1'b0);
    end
`ifdef WALK_PRESS_COUNT_EN
    want = 8'd255;
`else
    want = 8'd0;
`endif
    checks++;
    if (press_count !== want || dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL saturation: got count=%0d expected %0d", press_count, want);
    end
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_ack_lockout();
    test_simultaneous();
    test_reset_mid();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
